// File: rtl/bcd_chain_down_counter.sv
// Cascadable multi-digit down-counter with per-digit modulus and borrow chain.
// Define HOLD_AT_ZERO_EN to hold at all-zeros instead of wrapping.
module bcd_chain_down_counter #(
    parameter int                    DIGITS   = 2,
    parameter logic [4*DIGITS-1:0]   MOD_LIST = {4'd6, 4'd10}
) (
    input  logic                  clock,
    input  logic                  clrn,
    input  logic                  loadn,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   data,
    output logic [4*DIGITS-1:0]   count,
    output logic [DIGITS-1:0]     digit_tc,
    output logic                  zero,
    output logic                  tc
);

    generate
        if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
            $error("DIGITS must be 1..8");
        end
        for (genvar g = 0; g < DIGITS; g++) begin : g_mod_chk
            if (int'(MOD_LIST[4*g +: 4]) < 2 || int'(MOD_LIST[4*g +: 4]) > 10) begin : g_bad_mod
                $error("digit modulus must be 2..10");
            end
        end
    endgenerate

    logic [4*DIGITS-1:0] count_q;
    logic [4*DIGITS-1:0] count_d;
    // brw[i]: digits 0..i-1 are all zero, so digit i may step
    logic [DIGITS:0]     brw;
    logic                hold;

`ifdef HOLD_AT_ZERO_EN
    assign hold = brw[DIGITS];
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        brw[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            brw[i+1] = brw[i] & (count_q[4*i +: 4] == 4'd0);
        end
    end

    always_comb begin
        count_d = count_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (!loadn) begin
                if (data[4*i +: 4] >= MOD_LIST[4*i +: 4])
                    count_d[4*i +: 4] = MOD_LIST[4*i +: 4] - 4'd1;
                else
                    count_d[4*i +: 4] = data[4*i +: 4];
            end else if (enable && brw[i] && !hold) begin
                if (count_q[4*i +: 4] == 4'd0)
                    count_d[4*i +: 4] = MOD_LIST[4*i +: 4] - 4'd1;
                else
                    count_d[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count    = count_q;
    assign zero     = brw[DIGITS];
    assign digit_tc = {DIGITS{enable}} & brw[DIGITS:1];
    assign tc       = digit_tc[DIGITS-1];

endmodule

// File: tb/tb_bcd_chain_down_counter.sv
// Directed-vector bench for bcd_chain_down_counter with default parameters.
module tb_bcd_chain_down_counter;

    logic       clock;
    logic       clrn;
    logic       loadn;
    logic       enable;
    logic [7:0] data;
    logic [7:0] count;
    logic [1:0] digit_tc;
    logic       zero;
    logic       tc;

    int checks = 0;
    int errors = 0;

    bcd_chain_down_counter dut (
        .clock    (clock),
        .clrn     (clrn),
        .loadn    (loadn),
        .enable   (enable),
        .data     (data),
        .count    (count),
        .digit_tc (digit_tc),
        .zero     (zero),
        .tc       (tc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       ld;
        logic       en;
        logic [7:0] d;
        logic [1:0] dtc;
        logic [7:0] cnt;
        logic       z;
    } vec_t;

    localparam int NV = 19;
    vec_t v [NV];

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [7:0] hold_cnt [4];
    logic       hold_tc  [4];

    initial begin
        // ld en data  dtc(pre) count(post) zero(post)
        v[0]  = '{1'b0, 1'b1, 8'h25, 2'b11, 8'h25, 1'b0};
        v[1]  = '{1'b1, 1'b1, 8'h33, 2'b00, 8'h24, 1'b0};
        v[2]  = '{1'b1, 1'b1, 8'h33, 2'b00, 8'h23, 1'b0};
        v[3]  = '{1'b1, 1'b1, 8'h33, 2'b00, 8'h22, 1'b0};
        v[4]  = '{1'b1, 1'b1, 8'h33, 2'b00, 8'h21, 1'b0};
        v[5]  = '{1'b1, 1'b1, 8'h33, 2'b00, 8'h20, 1'b0};
        v[6]  = '{1'b1, 1'b1, 8'h33, 2'b01, 8'h19, 1'b0};
        v[7]  = '{1'b0, 1'b1, 8'h01, 2'b00, 8'h01, 1'b0};
        v[8]  = '{1'b1, 1'b1, 8'h33, 2'b00, 8'h00, 1'b1};
        v[9]  = '{1'b0, 1'b0, 8'hFF, 2'b00, 8'h59, 1'b0};
        v[10] = '{1'b0, 1'b0, 8'h7A, 2'b00, 8'h59, 1'b0};
        v[11] = '{1'b0, 1'b0, 8'h4C, 2'b00, 8'h49, 1'b0};
        v[12] = '{1'b0, 1'b0, 8'h12, 2'b00, 8'h12, 1'b0};
        v[13] = '{1'b1, 1'b1, 8'h33, 2'b00, 8'h11, 1'b0};
        v[14] = '{1'b1, 1'b0, 8'h33, 2'b00, 8'h11, 1'b0};
        v[15] = '{1'b1, 1'b1, 8'h33, 2'b00, 8'h10, 1'b0};
        v[16] = '{1'b1, 1'b0, 8'h33, 2'b00, 8'h10, 1'b0};
        v[17] = '{1'b1, 1'b1, 8'h33, 2'b01, 8'h09, 1'b0};
        v[18] = '{1'b1, 1'b1, 8'h33, 2'b00, 8'h08, 1'b0};

`ifdef HOLD_AT_ZERO_EN
        hold_cnt = '{8'h00, 8'h00, 8'h00, 8'h00};
        hold_tc  = '{1'b0, 1'b1, 1'b1, 1'b1};
`else
        hold_cnt = '{8'h00, 8'h59, 8'h58, 8'h57};
        hold_tc  = '{1'b0, 1'b1, 1'b0, 1'b0};
`endif

        clrn   = 1'b0;
        loadn  = 1'b1;
        enable = 1'b0;
        data   = 8'h00;
        #3;
        check("reset_count", count, 8'h00);
        check("reset_zero", {7'd0, zero}, 8'h01);
        check("reset_tc", {7'd0, tc}, 8'h00);
        check("reset_dtc", {6'd0, digit_tc}, 8'h00);

        @(negedge clock);
        clrn = 1'b1;
        for (int i = 0; i < NV; i++) begin
            loadn  = v[i].ld;
            enable = v[i].en;
            data   = v[i].d;
            #1;
            check($sformatf("v%0d_dtc", i), {6'd0, digit_tc}, {6'd0, v[i].dtc});
            check($sformatf("v%0d_tc", i), {7'd0, tc}, {7'd0, v[i].dtc[1]});
            @(posedge clock);
            #1;
            check($sformatf("v%0d_count", i), count, v[i].cnt);
            check($sformatf("v%0d_zero", i), {7'd0, zero}, {7'd0, v[i].z});
            @(negedge clock);
        end

        // load 01 then keep enable high through zero
        loadn  = 1'b0;
        enable = 1'b0;
        data   = 8'h01;
        @(posedge clock);
        #1;
        check("z_load01", count, 8'h01);
        @(negedge clock);
        loadn  = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("z%0d_tc", i), {7'd0, tc}, {7'd0, hold_tc[i]});
            @(posedge clock);
            #1;
            check($sformatf("z%0d_count", i), count, hold_cnt[i]);
            @(negedge clock);
        end

        // load from zero state still works
        loadn  = 1'b0;
        enable = 1'b1;
        data   = 8'h37;
        @(posedge clock);
        #1;
        check("load37", count, 8'h37);
        @(negedge clock);
        loadn  = 1'b1;
        enable = 1'b0;
        @(posedge clock);
        #2;
        clrn = 1'b0;
        #1;
        check("async_clr_count", count, 8'h00);
        check("async_clr_zero", {7'd0, zero}, 8'h01);
        check("async_clr_tc", {7'd0, tc}, 8'h00);

        // reset dominates a pending load
        @(negedge clock);
        loadn = 1'b0;
        data  = 8'h45;
        @(posedge clock);
        #1;
        check("clr_over_load", count, 8'h00);
        @(negedge clock);
        clrn = 1'b1;
        #1;
        @(posedge clock);
        #1;
        check("load_after_clr", count, 8'h45);
        @(negedge clock);
        loadn = 1'b1;
        enable = 1'b1;
        @(posedge clock);
        #2;
        clrn = 1'b0;
        #1;
        check("async_clr_midcount", count, 8'h00);
        enable = 1'b0;
        #1;
        check("async_clr_tc_en0", {7'd0, tc}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
